// File: rtl/pixel_stream_writer_if.sv
// Beat-serial input and frame-buffer write port of the pixel stream writer.
// The master drives the packet beats; the slave drives the write side.
interface pixel_stream_writer_if #(
  parameter int unsigned IN_W   = 2,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned PIX_W  = 8
);
  logic              axiiv;
  logic [IN_W-1:0]   axiid;
  logic              axiov;
  logic [ADDR_W-1:0] addr_axiod;
  logic [PIX_W-1:0]  pixel_axiod;
  logic              frame_done;
  logic              pkt_err;

  modport master (
    output axiiv, axiid,
    input  axiov, addr_axiod, pixel_axiod, frame_done, pkt_err
  );

  modport slave (
    input  axiiv, axiid,
    output axiov, addr_axiod, pixel_axiod, frame_done, pkt_err
  );
endinterface

// File: rtl/pixel_stream_writer.sv
// Turns a beat-serial packet (big-endian address header, then big-endian pixels)
// into single-cycle frame-buffer writes with a wrapping address counter.
module pixel_stream_writer #(
  parameter int unsigned IN_W   = 2,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned DEPTH  = 76800
) (
  input logic                  clk,
  input logic                  rst_n,
  pixel_stream_writer_if.slave bus
);
  localparam int unsigned HDR_BYTES = (ADDR_W + 7) / 8;
  localparam int unsigned PIX_BYTES = PIX_W / 8;
  localparam int unsigned BEATS     = 8 / IN_W;

  typedef enum logic [1:0] {StIdle, StHdr, StData, StDrop} state_e;

  state_e            state_q;
  logic [2:0]        beat_cnt_q;
  logic [2:0]        byte_cnt_q;
  logic [7:0]        byte_q;
  logic [ADDR_W-1:0] hdr_q;
  logic [PIX_W-1:0]  pix_q;
  logic [ADDR_W-1:0] addr_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [PIX_W-1:0]  pixel_q;
  logic              axiov_q;
  logic              frame_done_q;
  logic              pkt_err_q;

  logic [7:0]        byte_full;
  logic [ADDR_W-1:0] hdr_full;
  logic [PIX_W-1:0]  pix_full;
  logic              byte_done;
  logic              hdr_done;
  logic              pix_done;
  logic              addr_ok;
  logic              addr_last;

  // Partial bytes/words are kept zero-filled so the current beat can simply be shifted in.
  always_comb begin
    byte_full = (byte_q << IN_W) | 8'(bus.axiid);
    hdr_full  = (hdr_q << 8) | ADDR_W'(byte_full);
    pix_full  = (pix_q << 8) | PIX_W'(byte_full);
    byte_done = beat_cnt_q == 3'(BEATS - 1);
    hdr_done  = byte_done && (byte_cnt_q == 3'(HDR_BYTES - 1));
    pix_done  = byte_done && (byte_cnt_q == 3'(PIX_BYTES - 1));
    addr_ok   = {1'b0, hdr_full} < (ADDR_W + 1)'(DEPTH);
    addr_last = addr_cnt_q == ADDR_W'(DEPTH - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      beat_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      byte_q       <= '0;
      hdr_q        <= '0;
      pix_q        <= '0;
      addr_cnt_q   <= '0;
      addr_q       <= '0;
      pixel_q      <= '0;
      axiov_q      <= 1'b0;
      frame_done_q <= 1'b0;
      pkt_err_q    <= 1'b0;
    end else begin
      axiov_q      <= 1'b0;
      frame_done_q <= 1'b0;
      pkt_err_q    <= 1'b0;
      if (!bus.axiiv) begin
        // End of packet: a truncated header is an error, a partial pixel is just dropped.
        if (state_q == StHdr) pkt_err_q <= 1'b1;
        state_q    <= StIdle;
        beat_cnt_q <= '0;
        byte_cnt_q <= '0;
        byte_q     <= '0;
        hdr_q      <= '0;
        pix_q      <= '0;
      end else if (state_q != StDrop) begin
        if (state_q == StIdle) state_q <= StHdr;
        if (!byte_done) begin
          byte_q     <= byte_full;
          beat_cnt_q <= beat_cnt_q + 3'd1;
        end else begin
          byte_q     <= '0;
          beat_cnt_q <= '0;
          if (state_q == StData) begin
            if (pix_done) begin
              axiov_q      <= 1'b1;
              addr_q       <= addr_cnt_q;
              pixel_q      <= pix_full;
              frame_done_q <= addr_last;
              addr_cnt_q   <= addr_last ? '0 : addr_cnt_q + ADDR_W'(1);
              pix_q        <= '0;
              byte_cnt_q   <= '0;
            end else begin
              pix_q      <= pix_full;
              byte_cnt_q <= byte_cnt_q + 3'd1;
            end
          end else if (hdr_done) begin
            hdr_q      <= '0;
            byte_cnt_q <= '0;
            if (addr_ok) begin
              addr_cnt_q <= hdr_full;
              state_q    <= StData;
            end else begin
              pkt_err_q <= 1'b1;
              state_q   <= StDrop;
            end
          end else begin
            hdr_q      <= hdr_full;
            byte_cnt_q <= byte_cnt_q + 3'd1;
          end
        end
      end
    end
  end

  assign bus.axiov       = axiov_q;
  assign bus.addr_axiod  = addr_q;
  assign bus.pixel_axiod = pixel_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.pkt_err     = pkt_err_q;
endmodule

// File: tb/tb_pixel_stream_writer.sv
// Randomized packet bench for pixel_stream_writer; expected writes are derived from
// the packet byte list with plain arithmetic and checked every cycle.
module tb_pixel_stream_writer;
  localparam int IN_W      = 2;
  localparam int ADDR_W    = 17;
  localparam int PIX_W     = 8;
  localparam int DEPTH     = 76800;
  localparam int BEATS     = 8 / IN_W;
  localparam int HDR_BYTES = (ADDR_W + 7) / 8;
  localparam int PIX_BYTES = PIX_W / 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pixel_stream_writer_if #(.IN_W(IN_W), .ADDR_W(ADDR_W), .PIX_W(PIX_W)) a_if ();
  pixel_stream_writer #(.IN_W(IN_W), .ADDR_W(ADDR_W), .PIX_W(PIX_W), .DEPTH(DEPTH)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if.slave)
  );

  pixel_stream_writer_if #(.IN_W(4), .ADDR_W(17), .PIX_W(16)) b_if ();
  pixel_stream_writer #(.IN_W(4), .ADDR_W(17), .PIX_W(16), .DEPTH(76800)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if.slave)
  );

  int                n_checks = 0;
  int                n_pass   = 0;
  logic [7:0]        pkt_q[$];
  logic [ADDR_W-1:0] hold_addr = '0;
  logic [PIX_W-1:0]  hold_pix  = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_outs(input logic exp_ov, input logic exp_fd, input logic exp_err);
    check("axiov", 32'(a_if.axiov), 32'(exp_ov));
    check("frame_done", 32'(a_if.frame_done), 32'(exp_fd));
    check("pkt_err", 32'(a_if.pkt_err), 32'(exp_err));
    check("addr", 32'(a_if.addr_axiod), 32'(hold_addr));
    check("pixel", 32'(a_if.pixel_axiod), 32'(hold_pix));
  endtask

  task automatic mk_hdr(input longint unsigned hv);
    pkt_q.delete();
    for (int i = HDR_BYTES - 1; i >= 0; i--) pkt_q.push_back(8'(hv >> (8 * i)));
  endtask

  // Drive the first nbeats beats of pkt_q; optionally end the packet with one idle cycle.
  task automatic run_pkt(input int nbeats, input bit close);
    longint unsigned base    = 0;
    bit              dropped = 1'b0;
    for (int k = 0; k < nbeats; k++) begin
      int         b;
      int         j;
      logic [7:0] sh;
      logic       ov;
      logic       fd;
      logic       err;
      b  = k / BEATS;
      j  = k % BEATS;
      sh = pkt_q[b] >> (8 - IN_W * (j + 1));
      a_if.axiiv = 1'b1;
      a_if.axiid = sh[IN_W-1:0];
      @(posedge clk);
      #1;
      ov  = 1'b0;
      fd  = 1'b0;
      err = 1'b0;
      if (j == BEATS - 1) begin
        if (b == HDR_BYTES - 1) begin
          longint unsigned hv = 0;
          for (int i = 0; i < HDR_BYTES; i++) hv = hv * 256 + longint'(pkt_q[i]);
          hv = hv % (longint'(1) << ADDR_W);
          if (hv >= longint'(DEPTH)) begin
            err     = 1'b1;
            dropped = 1'b1;
          end else begin
            base = hv;
          end
        end else if (b >= HDR_BYTES && !dropped && (b - HDR_BYTES + 1) % PIX_BYTES == 0) begin
          longint unsigned n  = longint'((b - HDR_BYTES + 1) / PIX_BYTES - 1);
          longint unsigned pv = 0;
          longint unsigned wa;
          for (int i = b - PIX_BYTES + 1; i <= b; i++) pv = pv * 256 + longint'(pkt_q[i]);
          wa        = (base + n) % longint'(DEPTH);
          hold_addr = ADDR_W'(wa);
          hold_pix  = PIX_W'(pv);
          ov        = 1'b1;
          fd        = (wa == longint'(DEPTH - 1));
        end
      end
      check_outs(ov, fd, err);
    end
    if (close) begin
      a_if.axiiv = 1'b0;
      a_if.axiid = '0;
      @(posedge clk);
      #1;
      check_outs(1'b0, 1'b0, nbeats > 0 && nbeats < HDR_BYTES * BEATS);
    end
  endtask

  initial begin
    logic [7:0] b_bytes[5];
    a_if.axiiv = 1'b0;
    a_if.axiid = '0;
    b_if.axiiv = 1'b0;
    b_if.axiid = '0;
    #2;
    check_outs(1'b0, 1'b0, 1'b0);
    check("b_axiov_rst", 32'(b_if.axiov), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outs(1'b0, 1'b0, 1'b0);

    // Single 8-bit pixel at address 16
    mk_hdr(64'h10);
    pkt_q.push_back(8'hA5);
    run_pkt(pkt_q.size() * BEATS, 1'b1);

    // Wrap across the end of the frame
    mk_hdr(64'h12BFE);
    pkt_q.push_back(8'h11);
    pkt_q.push_back(8'h22);
    pkt_q.push_back(8'h33);
    run_pkt(pkt_q.size() * BEATS, 1'b1);

    // Out-of-range header, then a clean packet at address 0
    mk_hdr(64'h12C00);
    pkt_q.push_back(8'h55);
    pkt_q.push_back(8'h66);
    run_pkt(pkt_q.size() * BEATS, 1'b1);
    mk_hdr(64'h0);
    pkt_q.push_back(8'h7E);
    run_pkt(pkt_q.size() * BEATS, 1'b1);

    // Truncated pixel (silent) and truncated header (error)
    mk_hdr(64'h40);
    pkt_q.push_back(8'hC3);
    run_pkt(HDR_BYTES * BEATS + 2, 1'b1);
    mk_hdr(64'h40);
    run_pkt(5, 1'b1);

    for (int it = 0; it < 40; it++) begin
      int unsigned     r;
      longint unsigned start;
      int              npix;
      int              nb;
      r = $urandom_range(0, 9);
      if (r == 0) start = longint'(DEPTH) + longint'($urandom_range(0, (1 << ADDR_W) - 1 - DEPTH));
      else if (r < 4) start = longint'(DEPTH - int'($urandom_range(1, 4)));
      else start = longint'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 2) == 0) start = start + (longint'($urandom_range(0, 127)) << ADDR_W);
      mk_hdr(start);
      npix = int'($urandom_range(0, 6));
      for (int p = 0; p < npix * PIX_BYTES; p++) pkt_q.push_back(8'($urandom));
      nb = pkt_q.size() * BEATS;
      if ($urandom_range(0, 3) == 0) nb = int'($urandom_range(1, nb));
      run_pkt(nb, 1'b1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
        check_outs(1'b0, 1'b0, 1'b0);
      end
    end

    // 16-bit pixels on 4-bit beats
    b_bytes = '{8'h00, 8'h00, 8'h05, 8'hBE, 8'hEF};
    for (int k = 0; k < 10; k++) begin
      logic [7:0] sh;
      sh = b_bytes[k / 2] >> (4 * (1 - k % 2));
      b_if.axiiv = 1'b1;
      b_if.axiid = sh[3:0];
      @(posedge clk);
      #1;
      check("b_axiov", 32'(b_if.axiov), 32'(k == 9));
    end
    check("b_addr", 32'(b_if.addr_axiod), 32'd5);
    check("b_pixel", 32'(b_if.pixel_axiod), 32'hBEEF);
    b_if.axiiv = 1'b0;
    b_if.axiid = '0;
    @(posedge clk);
    #1;
    check("b_axiov_end", 32'(b_if.axiov), 32'd0);
    check("b_pkt_err", 32'(b_if.pkt_err), 32'd0);

    // Asynchronous reset in the middle of a pixel
    mk_hdr(64'h100);
    pkt_q.push_back(8'h9A);
    pkt_q.push_back(8'hBC);
    run_pkt(pkt_q.size() * BEATS, 1'b1);
    mk_hdr(64'h200);
    pkt_q.push_back(8'hDE);
    run_pkt(HDR_BYTES * BEATS + 2, 1'b0);
    #2;
    rst_n      = 1'b0;
    a_if.axiiv = 1'b0;
    a_if.axiid = '0;
    #1;
    hold_addr = '0;
    hold_pix  = '0;
    check_outs(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_outs(1'b0, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outs(1'b0, 1'b0, 1'b0);
    mk_hdr(64'h300);
    pkt_q.push_back(8'h5A);
    run_pkt(pkt_q.size() * BEATS, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
